fila_paradas: RTL
=================

# fila_paradas

Stop queue feeding the elevator control unit. It accepts hall/cabin requests as (origin, destination) floor pairs and stores them as a flat FIFO of stops (origin, then destination). It presents the head stop on `proxParada`, using value 0 to mean "no pending stop". The control unit pops one stop per `shift` pulse and wipes the queue with `clearSuperRam`.

## Interface
Parameters:
- `PROFUNDIDADE`, 16: number of stop entries; must be a power of two, ≥ 4.
- `LARGURA_ANDAR`, 4: floor code width. Floor 0 is reserved as "empty", so valid floors are 1..2^LARGURA_ANDAR−1.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; dominates every other input.
- `clearSuperRam` in 1: synchronous queue flush from the control unit.
- `shift` in 1: pop request, level signal from the control unit; acts on its rising edge only.
- `pedidoValido` in 1: request valid.
- `pedidoOrigem` in LARGURA_ANDAR: request origin floor.
- `pedidoDestino` in LARGURA_ANDAR: request destination floor.
- `pedidoPronto` out 1: queue can accept a request this cycle.
- `proxParada` out LARGURA_ANDAR: head stop, or 0 when empty.
- `vazia` out 1: count == 0.
- `cheia` out 1: count == PROFUNDIDADE.
- `ocupacao` out $clog2(PROFUNDIDADE)+1: number of stored stops.
- `erroPedido` out 1: one-cycle pulse when a request is rejected.
- `db_estado` out 2: write-FSM state, for debug display.

## Operation
- Storage: register array `mem`, head pointer `cab`, tail pointer `cauda`, counter `ocupacao`. Pointers wrap modulo PROFUNDIDADE.
- Write FSM states:
  - OCIOSO (00): `pedidoPronto` = 1 when `ocupacao` ≤ PROFUNDIDADE−2 and `clearSuperRam` = 0.
    - On `pedidoValido && pedidoPronto`, the request is checked. It is rejected if origin = 0, destination = 0, or origin = destination. A rejection pulses `erroPedido` next cycle and stays in OCIOSO.
    - Otherwise origin and destination are latched into internal registers and the FSM moves to GUARDA_ORIGEM.
  - GUARDA_ORIGEM (01): writes the origin at `cauda`, `cauda`+1, `ocupacao`+1; goes to GUARDA_DESTINO.
  - GUARDA_DESTINO (10): writes the destination at `cauda`, `cauda`+1, `ocupacao`+1; returns to OCIOSO.
  - Encoding 11 is unused and recovers to OCIOSO.
- Pop: `shift_d` registers `shift`. A pop occurs when `shift && !shift_d && ocupacao > 0`: `cab`+1, `ocupacao`−1. A pop attempt while empty is ignored.
- Simultaneous pop and write in one cycle: both pointers advance and `ocupacao` is unchanged.
- `proxParada` = `vazia` ? 0 : mem[cab], combinational from registers.
- `clearSuperRam`: pointers and count go to 0, FSM goes to OCIOSO, and any half-written request is discarded. `shift_d` still tracks `shift`.
- Reset values:
  - `cab`, `cauda`, `ocupacao`, `shift_d` = 0; FSM = OCIOSO.
  - Outputs: `proxParada` = 0, `vazia` = 1, `cheia` = 0, `erroPedido` = 0, `pedidoPronto` = 1, `db_estado` = 00.
  - `mem` contents are don't-care.

## Timing
- Request accepted at edge E. Origin is written at E+1, destination at E+2.
- For a request into an empty queue, `proxParada` shows the origin in the cycle after E+1.
- `pedidoPronto` is low in the two write cycles and can rise again after E+2.
- Pop latency: `proxParada` shows the next entry in the cycle after the edge that samples the `shift` rise. Holding `shift` high pops exactly once.
- `erroPedido` is high for exactly one cycle, after the rejecting edge.
- Priority per edge: `reset` > `clearSuperRam` > pop/write.

## Structure
- Shared package/constants file `elevador_pkg`:
  - `ANDAR_VAZIO` = 0.
  - FSM state codes `FILA_OCIOSO`, `FILA_GUARDA_ORIGEM`, `FILA_GUARDA_DESTINO`.
  - Default floor width, reused by the control unit.
- Sub-module `detector_borda`: registers `shift` and outputs the one-cycle rise pulse. It is reusable for the cabin and hall buttons.

## Test plan
- Reset, then request (3,7) in an empty queue: `pedidoPronto` drops for 2 cycles; `proxParada` = 3, `ocupacao` = 2. One `shift` rise gives `proxParada` = 7; a second gives 0 with `vazia` = 1.
- `shift` held high for 10 cycles with 4 stops queued: exactly one pop, `ocupacao` 4 → 3.
- Requests (5,5), (0,2) and (4,0): each gives a single `erroPedido` pulse with `ocupacao` unchanged.
- Fill with 8 requests (PROFUNDIDADE = 16): `cheia` = 1 and `pedidoPronto` = 0. One pop gives `pedidoPronto` still 0 (15 > 14); a second pop gives 1.
- `shift` rise in the same cycle as GUARDA_DESTINO with `ocupacao` = 5: afterwards `ocupacao` = 5 and the head has advanced. Wrap-around is checked by cycling 40 stops through and verifying FIFO order.
- `clearSuperRam` during GUARDA_ORIGEM: next cycle `ocupacao` = 0, `proxParada` = 0, FSM in OCIOSO, and the destination is never written.

Source files
------------

// File: rtl/elevador_pkg.sv
// Constants shared by the elevator blocks: floor width, empty-floor code
// and the write-FSM state codes of the stop queue.
package elevador_pkg;

  localparam int unsigned LARGURA_ANDAR_PADRAO = 4;
  localparam int unsigned ANDAR_VAZIO          = 0;

  typedef enum logic [1:0] {
    FILA_OCIOSO         = 2'b00,
    FILA_GUARDA_ORIGEM  = 2'b01,
    FILA_GUARDA_DESTINO = 2'b10
  } estadoFila_t;

endpackage

// File: rtl/detector_borda.sv
// Rising-edge detector: registers a level input and emits a one-cycle pulse
// in the cycle where the level goes from 0 to 1.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic sinal,
  output logic borda
);

  logic sinalAnterior;

  always_ff @(posedge clock) begin
    if (reset) sinalAnterior <= 1'b0;
    else       sinalAnterior <= sinal;
  end

  assign borda = sinal & ~sinalAnterior;

endmodule

// File: rtl/fila_paradas.sv
// Stop queue for the elevator control unit: each (origin, destination) request
// becomes two FIFO entries; the head stop is shown on proxParada (0 = none).
module fila_paradas
  import elevador_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE  = 16,
  parameter int unsigned LARGURA_ANDAR = LARGURA_ANDAR_PADRAO
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clearSuperRam,
  input  logic                         shift,
  input  logic                         pedidoValido,
  input  logic [LARGURA_ANDAR-1:0]     pedidoOrigem,
  input  logic [LARGURA_ANDAR-1:0]     pedidoDestino,
  output logic                         pedidoPronto,
  output logic [LARGURA_ANDAR-1:0]     proxParada,
  output logic                         vazia,
  output logic                         cheia,
  output logic [$clog2(PROFUNDIDADE):0] ocupacao,
  output logic                         erroPedido,
  output logic [1:0]                   db_estado
);

  localparam int unsigned PW = $clog2(PROFUNDIDADE);
  localparam logic [PW:0] OCUP_MAX      = (PW+1)'(PROFUNDIDADE);
  localparam logic [PW:0] LIMITE_PRONTO = (PW+1)'(PROFUNDIDADE - 2);
  localparam logic [LARGURA_ANDAR-1:0] VAZIO = LARGURA_ANDAR'(ANDAR_VAZIO);

  estadoFila_t estado, estadoProx;

  logic [LARGURA_ANDAR-1:0] mem [PROFUNDIDADE];
  logic [PW-1:0]            cab, cauda;
  logic [LARGURA_ANDAR-1:0] origemReg, destinoReg, dadoEscrita;
  logic bordaShift, pop, escreve, aceita, rejeita, pedidoInvalido;

  detector_borda uDetectorShift (
    .clock (clock),
    .reset (reset),
    .sinal (shift),
    .borda (bordaShift)
  );

  assign pedidoInvalido = (pedidoOrigem == VAZIO) || (pedidoDestino == VAZIO) ||
                          (pedidoOrigem == pedidoDestino);
  assign pop   = bordaShift && (ocupacao != '0);
  assign vazia = (ocupacao == '0);
  assign cheia = (ocupacao == OCUP_MAX);
  assign proxParada = vazia ? VAZIO : mem[cab];
  assign db_estado  = estado;

  // Admission is limited to two free slots so both halves of a request fit.
  always_comb begin
    estadoProx   = estado;
    pedidoPronto = 1'b0;
    escreve      = 1'b0;
    dadoEscrita  = origemReg;
    aceita       = 1'b0;
    rejeita      = 1'b0;
    case (estado)
      FILA_OCIOSO: begin
        pedidoPronto = (ocupacao <= LIMITE_PRONTO) && !clearSuperRam;
        aceita       = pedidoValido && pedidoPronto && !pedidoInvalido;
        rejeita      = pedidoValido && pedidoPronto && pedidoInvalido;
        if (aceita) estadoProx = FILA_GUARDA_ORIGEM;
      end
      FILA_GUARDA_ORIGEM: begin
        escreve     = !clearSuperRam;
        dadoEscrita = origemReg;
        estadoProx  = FILA_GUARDA_DESTINO;
      end
      FILA_GUARDA_DESTINO: begin
        escreve     = !clearSuperRam;
        dadoEscrita = destinoReg;
        estadoProx  = FILA_OCIOSO;
      end
      default: estadoProx = FILA_OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= FILA_OCIOSO;
      cab        <= '0;
      cauda      <= '0;
      ocupacao   <= '0;
      erroPedido <= 1'b0;
    end else begin
      erroPedido <= rejeita;
      if (clearSuperRam) begin
        estado   <= FILA_OCIOSO;
        cab      <= '0;
        cauda    <= '0;
        ocupacao <= '0;
      end else begin
        estado <= estadoProx;
        if (escreve) cauda <= cauda + PW'(1);
        if (pop)     cab   <= cab + PW'(1);
        ocupacao <= ocupacao + (PW+1)'(escreve) - (PW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && aceita) begin
      origemReg  <= pedidoOrigem;
      destinoReg <= pedidoDestino;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && escreve) mem[cauda] <= dadoEscrita;
  end

endmodule
